// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Synchronous up/down counter with programmable modulus, prescaler,
//   parallel load, wrap/saturate selection and a registered terminal-count
//   pulse. Also drives active-low seven-segment glyphs for every hex digit
//   of the count, so a board top level needs no separate decoders.
//   Instances cascade by feeding tc of one into enable of the next.
//
// Parameters
//   WIDTH     count register width, 1..32
//   MODULUS   count range 0..MODULUS-1, 2..2^WIDTH
//   PRESCALE  enabled cycles per count step, >= 1
//   DIGITS    hex digits driven, derived from WIDTH
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-low reset
//   enable      advances the prescaler / count
//   up          1 = count up, 0 = count down
//   saturate    1 = hold at the limit, 0 = wrap
//   load        synchronous parallel load strobe (overrides enable)
//   load_value  value to load, clamped to MODULUS-1
//   count       registered count
//   tc          registered terminal-count pulse
//   hex         active-low segments, digit k at hex[7k+6:7k], a..g = bit0..bit6

module param_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              PRESCALE = 1,
  localparam int             DIGITS   = (WIDTH + 3) / 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  saturate,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  // One prescaler bit minimum; with PRESCALE=1 it simply stays at zero.
  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    P_LAST    = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          at_limit;

  assign at_limit = up ? (count == MAX_COUNT) : (count == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
      presc <= '0;
    end else if (load) begin
      // MAX_COUNT always fits in WIDTH bits, so the clamp needs no wide compare.
      count <= (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      presc <= '0;
      tc    <= 1'b0;
    end else if (enable) begin
      if (presc == P_LAST) begin
        presc <= '0;
        tc    <= at_limit;
        if (at_limit) begin
          if (!saturate) begin
            count <= up ? '0 : MAX_COUNT;
          end
        end else begin
          count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        end
      end else begin
        presc <= presc + PW'(1);
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Top digit may be partial; zero-extend so it shows only the real bits.
  logic [4*DIGITS-1:0] count_padded;
  assign count_padded = (4*DIGITS)'(count);

  always_comb begin
    hex = '1;
    for (int k = 0; k < DIGITS; k++) begin
      hex[7*k +: 7] = seg7(count_padded[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

  logic clock = 1'b0;
  logic reset, enable, up, saturate, load;
  logic [7:0] lv;

  logic [7:0]  c0, c2;
  logic [3:0]  c1;
  logic [4:0]  c3;
  logic        t0, t1, t2, t3;
  logic [13:0] h0, h2, h3;
  logic [6:0]  h1;

  always #5 clock = ~clock;

  param_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_value(lv), .count(c0), .tc(t0), .hex(h0));
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_value(lv[3:0]), .count(c1), .tc(t1), .hex(h1));
  param_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(3)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_value(lv), .count(c2), .tc(t2), .hex(h2));
  param_updown_counter #(.WIDTH(5), .MODULUS(20), .PRESCALE(2)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .saturate(saturate),
    .load(load), .load_value(lv[4:0]), .count(c3), .tc(t3), .hex(h3));

  typedef struct packed {
    logic [3:0][7:0]  c;
    logic [3:0]       t;
    logic [3:0][13:0] h;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int wid[4] = '{8, 4, 8, 5};
  int mdl[4] = '{256, 10, 256, 20};
  int psc[4] = '{1, 1, 3, 2};
  int mc[4]  = '{0, 0, 0, 0};
  int mp[4]  = '{0, 0, 0, 0};
  int mt[4]  = '{0, 0, 0, 0};

  logic [6:0] glyph[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [13:0] hex_of(int val, int w);
    logic [13:0] r;
    int digits;
    r = '0;
    digits = (w + 3) / 4;
    for (int k = 0; k < digits; k++) r[7*k +: 7] = glyph[(val >> (4*k)) & 15];
    return r;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the negedge, advance the reference model to
  // the state after the coming posedge, queue it, and move to the next negedge.
  task automatic tick(input bit rst_n, input bit en, input bit u, input bit sat,
                      input bit ld, input logic [7:0] v);
    exp_t e;
    int lim, lvk;
    bit at_lim;
    reset = rst_n; enable = en; up = u; saturate = sat; load = ld; lv = v;
    for (int k = 0; k < 4; k++) begin
      lim = mdl[k] - 1;
      if (!rst_n) begin
        mc[k] = 0; mp[k] = 0; mt[k] = 0;
      end else if (ld) begin
        lvk = int'(v) % (1 << wid[k]);
        mc[k] = (lvk > lim) ? lim : lvk;
        mp[k] = 0; mt[k] = 0;
      end else if (en) begin
        mp[k] = mp[k] + 1;
        mt[k] = 0;
        if (mp[k] == psc[k]) begin
          mp[k] = 0;
          at_lim = u ? (mc[k] == lim) : (mc[k] == 0);
          mt[k] = at_lim ? 1 : 0;
          if (!(at_lim && sat))
            mc[k] = u ? (mc[k] + 1) % mdl[k] : (mc[k] + mdl[k] - 1) % mdl[k];
        end
      end else begin
        mt[k] = 0;
      end
      e.c[k] = 8'(mc[k]);
      e.t[k] = (mt[k] != 0);
      e.h[k] = hex_of(mc[k], wid[k]);
    end
    q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: every posedge that has a queued expectation is compared just after it.
  initial begin
    exp_t e;
    logic [3:0][7:0]  ac;
    logic [3:0]       at;
    logic [3:0][13:0] ah;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        ac[0] = c0; ac[1] = 8'(c1); ac[2] = c2; ac[3] = 8'(c3);
        at = {t3, t2, t1, t0};
        ah[0] = h0; ah[1] = 14'(h1); ah[2] = h2; ah[3] = h3;
        for (int k = 0; k < 4; k++) begin
          chk("count", k, 32'(ac[k]), 32'(e.c[k]));
          chk("tc",    k, 32'(at[k]), 32'(e.t[k]));
          chk("hex",   k, 32'(ah[k]), 32'(e.h[k]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  logic [7:0] edge_vals[8] = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd19, 8'd20, 8'd254, 8'd255};

  initial begin
    logic [7:0] v;
    reset = 1'b0; enable = 1'b0; up = 1'b1; saturate = 1'b0; load = 1'b0; lv = '0;
    @(negedge clock);

    // Reset held two edges with enable high, then release.
    tick(0, 1, 1, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 0, 8'h00);
    chk("rst_count", 0, 32'(c0), 32'd0);
    chk("rst_tc",    0, 32'(t0), 32'd0);
    chk("rst_hex",   0, 32'(h0), 32'(14'b1000000_1000000));
    tick(1, 1, 1, 0, 0, 8'h00);
    chk("first_step", 0, 32'(c0), 32'd1);

    // Up wrap from 254.
    tick(1, 0, 1, 0, 1, 8'd254);
    tick(1, 1, 1, 0, 0, 8'h00);
    chk("wrap_ff_hex", 0, 32'(h0), 32'(14'b0001110_0001110));
    tick(1, 1, 1, 0, 0, 8'h00);
    chk("wrap_zero", 0, 32'(c0), 32'd0);
    chk("wrap_tc",   0, 32'(t0), 32'd1);
    tick(1, 1, 1, 0, 0, 8'h00);

    // Down with saturate, then switch to wrap.
    tick(1, 0, 0, 1, 1, 8'd1);
    repeat (4) tick(1, 1, 0, 1, 0, 8'h00);
    chk("sat_hold_tc", 0, 32'(t0), 32'd1);
    tick(1, 1, 0, 0, 0, 8'h00);
    chk("down_wrap", 0, 32'(c0), 32'd255);

    // Clamp on load, then wrap in the small modulus.
    tick(1, 0, 1, 0, 1, 8'd12);
    chk("clamp", 1, 32'(c1), 32'd9);
    repeat (21) tick(1, 1, 1, 0, 0, 8'h00);

    // Prescaler: 9 edges from reset, then gaps in enable, then a load.
    tick(0, 0, 1, 0, 0, 8'h00);
    tick(1, 1, 1, 0, 0, 8'h00);
    tick(1, 1, 1, 0, 0, 8'h00);
    tick(1, 1, 1, 0, 0, 8'h00);
    chk("presc_edge3", 2, 32'(c2), 32'd1);
    repeat (6) tick(1, 1, 1, 0, 0, 8'h00);
    chk("presc_edge9", 2, 32'(c2), 32'd3);
    tick(0, 0, 1, 0, 0, 8'h00);
    repeat (4) tick(1, 1, 1, 0, 0, 8'h00);
    repeat (5) tick(1, 0, 1, 0, 0, 8'h00);
    repeat (3) tick(1, 1, 1, 0, 0, 8'h00);
    tick(1, 1, 1, 0, 1, 8'h20);
    repeat (3) tick(1, 1, 1, 0, 0, 8'h00);

    // Reset with a simultaneous load mid-prescale.
    tick(1, 0, 1, 0, 1, 8'h37);
    tick(1, 1, 1, 0, 0, 8'h00);
    tick(0, 1, 1, 0, 1, 8'h55);
    chk("rst_over_load", 2, 32'(c2), 32'd0);
    repeat (3) tick(1, 1, 1, 0, 0, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 7)] : 8'($urandom);
      tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0), v);
    end

    tick(1, 0, 1, 0, 0, 8'h00);
    @(negedge clock);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
